// File: rtl/rle_pkg.sv
// ============================================================
// rle_pkg: shared widths, stop word and FSM states for rle_encoder
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

package rle_pkg;

  localparam int LEN_W   = 10;
  localparam int COLOR_W = 8;
  localparam int INSTR_W = 18;

  localparam logic [INSTR_W-1:0] STOP_WORD = 18'h500;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SPLIT = 3'd2,
    NEW   = 3'd3,
    STOP  = 3'd4
  } state_e;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [LEN_W-1:0]   len,
                                                    input logic [COLOR_W-1:0] color);
    return {len, color};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rle_encoder_if.sv
// ============================================================
// rle_encoder_if: pixel stream in, instruction stream out
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

interface rle_encoder_if;
  import rle_pkg::*;

  logic               pix_valid;
  logic               pix_ready;
  logic [COLOR_W-1:0] pix_data;
  logic               pix_eol;
  logic               pix_eof;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic               frame_done;

  // master is the encoder, slave is the pixel source plus instruction sink
  modport master (
    input  pix_valid, pix_data, pix_eol, pix_eof, instr_ready,
    output pix_ready, instr_valid, instr_data, frame_done
  );

  modport slave (
    output pix_valid, pix_data, pix_eol, pix_eof, instr_ready,
    input  pix_ready, instr_valid, instr_data, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/rle_out_reg.sv
// ============================================================
// rle_out_reg: single-entry valid/ready holding register
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module rle_out_reg #(
  parameter int WIDTH = 18
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_data,
  output logic                  valid,
  input  wire logic             ready,
  output logic [WIDTH-1:0]      data
);

  // load wins over drain: the caller only loads when the slot is free or draining
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rle_encoder.sv
// ============================================================
// rle_encoder: run-length encodes pixels into {len,colour} words
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module rle_encoder
  import rle_pkg::*;
#(
  parameter int MAX_RUN = 1023
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  rle_encoder_if.master bus
);

  state_e             state;
  logic [LEN_W-1:0]   cur_len;
  logic [COLOR_W-1:0] cur_color;
  logic               pend_new;
  logic               pend_eof;
  logic               frame_done_q;

  logic               eol;
  logic               can_emit;
  logic               xfer;
  logic               same;
  logic               closes;
  logic               split;
  logic [LEN_W-1:0]   nlen;
  logic [LEN_W-1:0]   old_len;
  logic               load;
  logic [INSTR_W-1:0] load_data;

  assign eol           = bus.pix_eol || bus.pix_eof;
  assign can_emit      = !bus.instr_valid || bus.instr_ready;
  assign bus.pix_ready = rst_n && ((state == IDLE) || (state == RUN)) && can_emit;
  assign xfer          = bus.pix_valid && bus.pix_ready;
  assign same          = (bus.pix_data == cur_color);
  assign nlen          = cur_len + LEN_W'(1);
  assign closes        = same && ((nlen == LEN_W'(MAX_RUN)) || eol);
  assign old_len       = same ? nlen : cur_len;
  // {5,00} would alias the stop word, so such a run goes out as 4 + 1
  assign split         = (old_len == LEN_W'(5)) && (cur_color == '0);
  assign bus.frame_done = frame_done_q;

  always_comb begin
    load      = 1'b0;
    load_data = '0;
    case (state)
      IDLE: begin
        if (xfer && eol) begin
          load      = 1'b1;
          load_data = make_instr(LEN_W'(1), bus.pix_data);
        end
      end
      RUN: begin
        if (xfer && (closes || !same)) begin
          load      = 1'b1;
          load_data = split ? make_instr(LEN_W'(4), '0) : make_instr(old_len, cur_color);
        end
      end
      SPLIT: begin
        load      = can_emit;
        load_data = make_instr(LEN_W'(1), '0);
      end
      NEW: begin
        load      = can_emit;
        load_data = make_instr(LEN_W'(1), cur_color);
      end
      STOP: begin
        load      = can_emit;
        load_data = STOP_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_len      <= '0;
      cur_color    <= '0;
      pend_new     <= 1'b0;
      pend_eof     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // data words never equal the stop word, so matching on data is exact
      frame_done_q <= bus.instr_valid && bus.instr_ready && (bus.instr_data == STOP_WORD);
      case (state)
        IDLE: begin
          if (xfer) begin
            cur_color <= bus.pix_data;
            if (eol) begin
              cur_len <= '0;
              state   <= bus.pix_eof ? STOP : IDLE;
            end else begin
              cur_len <= LEN_W'(1);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (same && closes) begin
              cur_len  <= '0;
              pend_new <= 1'b0;
              pend_eof <= bus.pix_eof;
              state    <= split ? SPLIT : (bus.pix_eof ? STOP : IDLE);
            end else if (same) begin
              cur_len <= nlen;
            end else begin
              cur_color <= bus.pix_data;
              cur_len   <= LEN_W'(1);
              pend_new  <= eol;
              pend_eof  <= bus.pix_eof;
              state     <= split ? SPLIT : (eol ? NEW : RUN);
            end
          end
        end
        SPLIT: begin
          if (can_emit) begin
            if (pend_new)                state <= NEW;
            else if (pend_eof)           state <= STOP;
            else if (cur_len != '0)      state <= RUN;
            else                         state <= IDLE;
          end
        end
        NEW: begin
          if (can_emit) begin
            cur_len  <= '0;
            pend_new <= 1'b0;
            state    <= pend_eof ? STOP : IDLE;
          end
        end
        STOP: begin
          if (can_emit) begin
            pend_new <= 1'b0;
            pend_eof <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rle_out_reg #(
    .WIDTH (INSTR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .valid     (bus.instr_valid),
    .ready     (bus.instr_ready),
    .data      (bus.instr_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_rle_encoder.sv
// ============================================================
// tb_rle_encoder: directed vectors against hand-computed RLE output
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rle_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rle_encoder_if bus ();

  rle_encoder #(
    .MAX_RUN (1023)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          fd_cnt = 0;
  int          fd_cyc = -1;
  int          stop_cyc = -1;
  int          got_base = 0;
  logic [17:0] got_q[$];
  int          xfer_cyc_q[$];
  logic [17:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.instr_valid && bus.instr_ready) begin
        got_q.push_back(bus.instr_data);
        xfer_cyc_q.push_back(cyc);
        if (bus.instr_data == 18'h500) stop_cyc <= cyc;
      end
      if (bus.frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ins(input int len, input logic [7:0] c);
    return {10'(len), c};
  endfunction

  // called and returns at 1ns after a rising edge
  task automatic send_pix(input logic [7:0] d, input logic eol, input logic eof);
    int n = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_eol   = eol;
    bus.pix_eof   = eof;
    @(negedge clk);
    while (!bus.pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL pix_timeout got=stalled exp=accepted");
    end
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_eol   = 1'b0;
    bus.pix_eof   = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic cmp_seq(input string tag, input logic [17:0] exp[$]);
    check({tag, "_cnt"}, got_q.size() - got_base, exp.size());
    foreach (exp[i])
      check(tag, (got_base + i < got_q.size()) ? got_q[got_base + i] : 18'h3ffff, exp[i]);
    got_base = got_q.size();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    int b2b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'h00;
    bus.pix_eol     = 1'b0;
    bus.pix_eof     = 1'b0;
    bus.instr_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.instr_valid, 0);
    check("rst_data",  bus.instr_data, 0);
    check("rst_fd",    bus.frame_done, 0);
    check("rst_prdy",  bus.pix_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_prdy", bus.pix_ready, 1);
    @(posedge clk);
    #1;

    // line A,A,A,B
    fd0 = fd_cnt;
    send_pix(8'h49, 0, 0);
    send_pix(8'h49, 0, 0);
    send_pix(8'h49, 0, 0);
    send_pix(8'h92, 1, 0);
    settle();
    exp_q = '{ins(3, 8'h49), ins(1, 8'h92)};
    cmp_seq("line_aaab", exp_q);
    check("line_no_fd", fd_cnt - fd0, 0);

    // single-pixel frame
    fd0 = fd_cnt;
    send_pix(8'h03, 1, 1);
    settle();
    exp_q = '{ins(1, 8'h03), 18'h500};
    cmp_seq("single_frame", exp_q);
    check("single_fd", fd_cnt - fd0, 1);

    // 5 x 00 then E0 eof: split path, back-to-back emission
    fd0 = fd_cnt;
    repeat (5) send_pix(8'h00, 0, 0);
    b2b0 = xfer_cyc_q.size();
    send_pix(8'hE0, 1, 1);
    settle();
    exp_q = '{ins(4, 8'h00), ins(1, 8'h00), ins(1, 8'hE0), 18'h500};
    cmp_seq("split_frame", exp_q);
    check("split_fd", fd_cnt - fd0, 1);
    check("fd_timing", fd_cyc, stop_cyc + 1);
    if (xfer_cyc_q.size() >= b2b0 + 4)
      check("b2b_span", xfer_cyc_q[b2b0 + 3] - xfer_cyc_q[b2b0], 3);
    else
      check("b2b_cnt", xfer_cyc_q.size() - b2b0, 4);

    // 5 x 00 closed by eol on a same-colour pixel, then 6 x 00, then 5 x 01
    repeat (4) send_pix(8'h00, 0, 0);
    send_pix(8'h00, 1, 0);
    repeat (5) send_pix(8'h00, 0, 0);
    send_pix(8'h00, 1, 0);
    repeat (4) send_pix(8'h01, 0, 0);
    send_pix(8'h01, 1, 0);
    settle();
    exp_q = '{ins(4, 8'h00), ins(1, 8'h00), ins(6, 8'h00), ins(5, 8'h01)};
    cmp_seq("run_lengths", exp_q);

    // MAX_RUN boundary
    for (int i = 0; i < 1030; i++) send_pix(8'h1C, (i == 1029), 0);
    settle();
    exp_q = '{ins(1023, 8'h1C), ins(7, 8'h1C)};
    cmp_seq("max_run", exp_q);

    // sink stalls 10 cycles with an instruction pending
    bus.instr_ready = 1'b0;
    send_pix(8'h49, 0, 0);
    send_pix(8'h92, 0, 0);
    fork
      send_pix(8'h25, 1, 0);
      begin
        repeat (10) begin
          @(negedge clk);
          check("hold_data",  bus.instr_data, ins(1, 8'h49));
          check("hold_valid", bus.instr_valid, 1);
          check("hold_prdy",  bus.pix_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
      end
    join
    settle();
    exp_q = '{ins(1, 8'h49), ins(1, 8'h92), ins(1, 8'h25)};
    cmp_seq("stall", exp_q);

    // reset while the split continuation is pending
    repeat (5) send_pix(8'h00, 0, 0);
    bus.instr_ready = 1'b0;
    send_pix(8'h25, 0, 0);
    check("split_held", bus.instr_data, ins(4, 8'h00));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("rst_split_valid", bus.instr_valid, 0);
    @(posedge clk);
    #1;
    settle();
    exp_q = {};
    cmp_seq("rst_split_none", exp_q);
    send_pix(8'h25, 1, 0);
    settle();
    exp_q = '{ins(1, 8'h25)};
    cmp_seq("restart", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
